// File: rtl/axi_interconnect_pkg.sv
// Shared constants, FSM encoding and the index-width helper for the crossbar arbiter.
`timescale 1ns/1ps
package axi_interconnect_pkg;

   localparam int ARB_MODE_RR  = 0;
   localparam int ARB_MODE_FIX = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Bits needed to hold the value v, never less than 1.
   function automatic int LOG2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) <= v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_arbit_pick.sv
// Combinational winner selection: round-robin from last_user+1, or lowest index first.
`timescale 1ns/1ps
module axi_interconnect_crossbar_arbit_pick
   import axi_interconnect_pkg::*;
#(
   parameter int NUM   = 4,
   parameter int WIDTH = LOG2(NUM - 1),
   parameter int MODE  = ARB_MODE_RR
) (
   input  logic [NUM-1:0]   user_req,
   input  logic [WIDTH-1:0] last_user,
   output logic [NUM-1:0]   win_onehot,
   output logic [WIDTH-1:0] win_id
);

   logic [WIDTH:0]     start_idx;
   logic [NUM:0]       start_bit;
   logic [2*NUM-1:0]   req_dbl;
   logic [2*NUM-1:0]   gnt_dbl;
   logic [NUM-1:0]     rr_onehot;
   logic [NUM-1:0]     fix_onehot;

   // start_bit reaches 1<<NUM when last_user=NUM-1, which lands on bit 0 of the upper copy.
   assign start_idx  = {1'b0, last_user} + (WIDTH+1)'(1);
   assign start_bit  = (NUM+1)'(1) << start_idx;
   assign req_dbl    = {user_req, user_req};
   assign gnt_dbl    = req_dbl & ~(req_dbl - (2*NUM)'(start_bit));
   assign rr_onehot  = gnt_dbl[NUM-1:0] | gnt_dbl[2*NUM-1:NUM];
   assign fix_onehot = user_req & (~user_req + NUM'(1));
   assign win_onehot = (MODE == ARB_MODE_FIX) ? fix_onehot : rr_onehot;

   // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      win_id = '0;
      for (int b = 0; b < WIDTH; b++) begin
         for (int i = 0; i < NUM; i++) begin
            if (i[b]) win_id[b] = win_id[b] | win_onehot[i];
         end
      end
   end

endmodule

// File: rtl/axi_interconnect_crossbar_arbit_rr_lock.sv
// Grant-locking arbiter for one crossbar slave port; zero-bubble hand-over on user_done.
// Optional watchdog forced release is built only when ARBIT_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module axi_interconnect_crossbar_arbit_rr_lock
   import axi_interconnect_pkg::*;
#(
   parameter int NUM     = 4,
   parameter int WIDTH   = LOG2(NUM - 1),
   parameter int MODE    = ARB_MODE_RR,
   parameter int TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM-1:0]   user_req,
   input  logic             user_done,
   output logic             gnt_valid,
   output logic [NUM-1:0]   gnt_onehot,
   output logic [WIDTH-1:0] gnt_id,
   output logic [WIDTH-1:0] last_user,
   output logic             timeout_err,
   output logic [WIDTH-1:0] err_id
);

   arb_state_e       state_q;
   logic             gnt_valid_q;
   logic [NUM-1:0]   gnt_onehot_q;
   logic [WIDTH-1:0] gnt_id_q;
   logic [WIDTH-1:0] last_user_q;
   logic [WIDTH-1:0] arb_ptr_d;
   logic [NUM-1:0]   win_onehot;
   logic [WIDTH-1:0] win_id;
   logic             wd_fire;
   logic             release_d;

`ifdef ARBIT_TIMEOUT_EN
   localparam int WD_W = LOG2(TIMEOUT - 1);
   logic [WD_W-1:0]  wd_q;
   logic             timeout_err_q;
   logic [WIDTH-1:0] err_id_q;

   assign wd_fire     = (state_q == ST_BUSY) && !user_done && (wd_q == WD_W'(TIMEOUT - 1));
   assign timeout_err = timeout_err_q;
   assign err_id      = err_id_q;
`else
   assign wd_fire     = 1'b0;
   assign timeout_err = 1'b0;
   assign err_id      = '0;
`endif

   // On release the pointer must already reflect the outgoing holder, so arbitrate from gnt_id.
   assign release_d = (state_q == ST_BUSY) && (user_done || wd_fire);
   assign arb_ptr_d = (state_q == ST_BUSY) ? gnt_id_q : last_user_q;

   axi_interconnect_crossbar_arbit_pick #(
      .NUM   (NUM),
      .WIDTH (WIDTH),
      .MODE  (MODE)
   ) u_pick (
      .user_req   (user_req),
      .last_user  (arb_ptr_d),
      .win_onehot (win_onehot),
      .win_id     (win_id)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         gnt_valid_q  <= 1'b0;
         gnt_onehot_q <= '0;
         gnt_id_q     <= '0;
         last_user_q  <= WIDTH'(NUM - 1);
`ifdef ARBIT_TIMEOUT_EN
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
         err_id_q      <= '0;
`endif
      end else begin
`ifdef ARBIT_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (|user_req) begin
                  state_q      <= ST_BUSY;
                  gnt_valid_q  <= 1'b1;
                  gnt_onehot_q <= win_onehot;
                  gnt_id_q     <= win_id;
`ifdef ARBIT_TIMEOUT_EN
                  wd_q         <= '0;
`endif
               end
            end
            ST_BUSY: begin
               if (release_d) begin
                  last_user_q <= gnt_id_q;
`ifdef ARBIT_TIMEOUT_EN
                  if (wd_fire) begin
                     timeout_err_q <= 1'b1;
                     err_id_q      <= gnt_id_q;
                  end
`endif
                  if (|user_req) begin
                     gnt_onehot_q <= win_onehot;
                     gnt_id_q     <= win_id;
`ifdef ARBIT_TIMEOUT_EN
                     wd_q         <= '0;
`endif
                  end else begin
                     state_q      <= ST_IDLE;
                     gnt_valid_q  <= 1'b0;
                     gnt_onehot_q <= '0;
                  end
               end
`ifdef ARBIT_TIMEOUT_EN
               else begin
                  wd_q <= wd_q + WD_W'(1);
               end
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt_valid  = gnt_valid_q;
   assign gnt_onehot = gnt_onehot_q;
   assign gnt_id     = gnt_id_q;
   assign last_user  = last_user_q;

endmodule

// File: tb/tb_axi_interconnect_crossbar_arbit_rr_lock.sv
// Bench: round-robin and fixed-priority arbiters on shared stimulus, vector table plus model.
`timescale 1ns/1ps
module tb_axi_interconnect_crossbar_arbit_rr_lock;

   localparam int NUM     = 4;
   localparam int TIMEOUT = 8;
`ifdef ARBIT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int HOLD = TO_EN ? 5 : 10;

   logic           clk = 1'b0;
   logic           rst;
   logic [NUM-1:0] user_req;
   logic           user_done;

   logic           r_valid, f_valid;
   logic [NUM-1:0] r_onehot, f_onehot;
   logic [1:0]     r_id, f_id, r_last, f_last, r_errid, f_errid;
   logic           r_terr, f_terr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_interconnect_crossbar_arbit_rr_lock #(.NUM(NUM), .MODE(0), .TIMEOUT(TIMEOUT)) dut_rr (
      .clk(clk), .rst(rst), .user_req(user_req), .user_done(user_done),
      .gnt_valid(r_valid), .gnt_onehot(r_onehot), .gnt_id(r_id), .last_user(r_last),
      .timeout_err(r_terr), .err_id(r_errid)
   );

   axi_interconnect_crossbar_arbit_rr_lock #(.NUM(NUM), .MODE(1), .TIMEOUT(TIMEOUT)) dut_fix (
      .clk(clk), .rst(rst), .user_req(user_req), .user_done(user_done),
      .gnt_valid(f_valid), .gnt_onehot(f_onehot), .gnt_id(f_id), .last_user(f_last),
      .timeout_err(f_terr), .err_id(f_errid)
   );

   // Abstract view of one arbiter: who holds the port, for how long, and who was served last.
   typedef struct {
      bit busy;
      int id;
      int last;
      int held;
      bit terr;
      int errid;
   } model_t;

   typedef struct {
      logic [3:0] req;
      bit         done;
      int         reps;
      bit         exp_valid;
      int         exp_id;
      int         exp_last;
   } vec_t;

   model_t m[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] req, input int ptr, input int mode);
      if (mode == 1) begin
         for (int i = 0; i < NUM; i++) if (req[i]) return i;
      end else begin
         for (int k = 1; k <= NUM; k++) if (req[(ptr + k) % NUM]) return (ptr + k) % NUM;
      end
      return 0;
   endfunction

   function automatic model_t model_next(input model_t s, input int mode, input bit r,
                                         input logic [3:0] req, input bit done);
      model_t n;
      bit     forced;
      n = s;
      n.terr = 1'b0;
      if (r) begin
         n = '{busy: 1'b0, id: 0, last: NUM - 1, held: 0, terr: 1'b0, errid: 0};
      end else if (!s.busy) begin
         if (req != 0) begin
            n.busy = 1'b1;
            n.id   = pick(req, s.last, mode);
            n.held = 0;
         end
      end else begin
         forced = TO_EN && !done && (s.held == TIMEOUT - 1);
         if (done || forced) begin
            n.last = s.id;
            if (forced) begin
               n.terr  = 1'b1;
               n.errid = s.id;
            end
            if (req != 0) begin
               n.id   = pick(req, s.id, mode);
               n.held = 0;
            end else begin
               n.busy = 1'b0;
            end
         end else begin
            n.held = s.held + 1;
         end
      end
      return n;
   endfunction

   task automatic compare_model(input int d);
      string tag;
      tag = (d == 0) ? "rr" : "fix";
      check({tag, ".valid"}, (d == 0) ? r_valid : f_valid, m[d].busy);
      check({tag, ".onehot"}, (d == 0) ? r_onehot : f_onehot, m[d].busy ? (32'd1 << m[d].id) : 32'd0);
      if (m[d].busy) check({tag, ".id"}, (d == 0) ? r_id : f_id, m[d].id);
      check({tag, ".last"}, (d == 0) ? r_last : f_last, m[d].last);
      check({tag, ".terr"}, (d == 0) ? r_terr : f_terr, m[d].terr);
      check({tag, ".errid"}, (d == 0) ? r_errid : f_errid, m[d].errid);
   endtask

   task automatic tick();
      m[0] = model_next(m[0], 0, rst, user_req, user_done);
      m[1] = model_next(m[1], 1, rst, user_req, user_done);
      @(posedge clk);
      #1;
      compare_model(0);
      compare_model(1);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{4'b0110, 1'b0, 1,    1'b1, 1, 3};
      vecs[1] = '{4'b1111, 1'b0, HOLD, 1'b1, 1, 3};
      vecs[2] = '{4'b1111, 1'b1, 1,    1'b1, 2, 1};
      vecs[3] = '{4'b1000, 1'b1, 1,    1'b1, 3, 2};
      vecs[4] = '{4'b1001, 1'b1, 1,    1'b1, 0, 3};
      vecs[5] = '{4'b1001, 1'b1, 1,    1'b1, 3, 0};
      vecs[6] = '{4'b0000, 1'b1, 1,    1'b0, 0, 3};
      vecs[7] = '{4'b0000, 1'b1, 1,    1'b0, 0, 3};
      vecs[8] = '{4'b1000, 1'b0, 1,    1'b1, 3, 3};
      vecs[9] = '{4'b0000, 1'b1, 1,    1'b0, 0, 3};

      rst = 1'b1;
      user_req = '0;
      user_done = 1'b0;
      tick();
      tick();
      check("reset.valid", r_valid, 0);
      check("reset.onehot", r_onehot, 0);
      check("reset.id", r_id, 0);
      check("reset.last", r_last, 3);
      check("reset.terr", r_terr, 0);
      check("reset.errid", r_errid, 0);
      rst = 1'b0;

      for (int v = 0; v < 10; v++) begin
         for (int r = 0; r < vecs[v].reps; r++) begin
            user_req  = vecs[v].req;
            user_done = vecs[v].done;
            tick();
            check($sformatf("vec%0d.valid", v), r_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d.onehot", v), r_onehot,
                  vecs[v].exp_valid ? (32'd1 << vecs[v].exp_id) : 32'd0);
            if (vecs[v].exp_valid) check($sformatf("vec%0d.id", v), r_id, vecs[v].exp_id);
            check($sformatf("vec%0d.last", v), r_last, vecs[v].exp_last);
         end
      end

      // Fixed priority: later lower-index request wins at the hand-over.
      rst = 1'b1; user_req = '0; user_done = 1'b0;
      tick();
      rst = 1'b0;
      user_req = 4'b1100;
      tick();
      check("fix.first_id", f_id, 2);
      user_req = 4'b1110;
      tick();
      check("fix.locked_id", f_id, 2);
      user_done = 1'b1;
      tick();
      check("fix.handover_valid", f_valid, 1);
      check("fix.handover_id", f_id, 1);
      check("rr.handover_id", r_id, 3);
      user_req = 4'b0000;
      tick();
      check("fix.drop_valid", f_valid, 0);
      user_done = 1'b0;

      // Reset in the middle of a held grant.
      user_req = 4'b0010;
      tick();
      check("midrst.pre_valid", r_valid, 1);
      rst = 1'b1;
      tick();
      check("midrst.valid", r_valid, 0);
      check("midrst.terr", r_terr, 0);
      rst = 1'b0;

      // Holder 0 never completes: forced release only with the watchdog built.
      user_req = 4'b1111;
      user_done = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         check($sformatf("wd.t%0d.id", t), r_id, (TO_EN && t >= 9) ? 1 : 0);
         check($sformatf("wd.t%0d.terr", t), r_terr, (TO_EN && t == 9) ? 1 : 0);
         check($sformatf("wd.t%0d.valid", t), r_valid, 1);
      end

      for (int c = 0; c < 500; c++) begin
         rst       = ($urandom_range(0, 59) == 0);
         user_req  = 4'($urandom);
         user_done = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
